// File: rtl/lifegame_pkg.sv
// Shared types and constants for the Game-of-Life generation engine.
// Also holds the default B3/S23 rule masks (bit n = neighbour count n).
package lifegame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RD,
        LATCH,
        CELL,
        WR,
        DONE
    } state_t;

    localparam logic [8:0] RULE_B3  = 9'b000001000;
    localparam logic [8:0] RULE_S23 = 9'b000001100;

endpackage

// File: rtl/lifegame_gen_engine_if.sv
// Frame RAM bus between the generation engine (master) and the ping-pong row RAMs (slave).
interface lifegame_gen_engine_if #(
    parameter int COLS = 640,
    parameter int ROWS = 480
);
    localparam int AW = $clog2(ROWS);

    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [COLS-1:0] rd_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [COLS-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );

endinterface

// File: rtl/lifegame_cell_rule.sv
// Combinational Life rule: 3x3 neighbourhood plus birth/survive masks -> next cell state.
// Index 0 of each 3-bit slice is column x-1, index 2 is column x+1.
module lifegame_cell_rule (
    input  logic [2:0] top,
    input  logic [2:0] mid,
    input  logic [2:0] bot,
    input  logic [8:0] rule_birth,
    input  logic [8:0] rule_survive,
    output logic       alive
);

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 3; i++) begin
            count = count + {3'b000, top[i]} + {3'b000, bot[i]};
        end
        count = count + {3'b000, mid[0]} + {3'b000, mid[2]};
        alive = mid[1] ? rule_survive[count] : rule_birth[count];
    end

endmodule

// File: rtl/lifegame_gen_engine.sv
// One Game-of-Life generation per start pulse: streams source rows through a three-row
// window, evaluates one cell per cycle and writes each finished row to the other buffer.
module lifegame_gen_engine
    import lifegame_pkg::*;
#(
    parameter int COLS  = 640,
    parameter int ROWS  = 480,
    parameter int WRAP  = 0,
    parameter int GEN_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              seed_mode,
    input  logic                              seed_bit,
    output logic                              seed_req,
    input  logic [8:0]                        rule_birth,
    input  logic [8:0]                        rule_survive,
    lifegame_gen_engine_if.master             ram,
    output logic                              buf_sel,
    output logic                              busy,
    output logic                              done,
    output logic [GEN_W-1:0]                  gen_count,
    output logic [$clog2(ROWS*COLS+1)-1:0]    pop_count
);

    localparam int AW = $clog2(ROWS);
    localparam int XW = $clog2(COLS);
    localparam int PW = $clog2(ROWS*COLS+1);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS-1);
    localparam logic [XW-1:0] LAST_COL = XW'(COLS-1);

    state_t          state_q, state_d;
    logic [1:0]      prime_q;
    logic [AW-1:0]   y_q;
    logic [XW-1:0]   x_q, xm, xp;
    logic [COLS-1:0] top_q, mid_q, bot_q, row_q;
    logic            seed_q;
    logic [8:0]      birth_q, survive_q;
    logic [PW-1:0]   pop_acc_q;
    logic            left_ok, right_ok, rule_cell, new_cell;
    logic [2:0]      top_w, mid_w, bot_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Control is decoded from the state register only, so no input reaches an output.
    always_comb begin
        state_d     = state_q;
        ram.rd_en   = 1'b0;
        ram.rd_addr = '0;
        ram.wr_en   = 1'b0;
        seed_req    = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = PRIME;
            PRIME: begin
                if (prime_q == 2'd0 && WRAP != 0) begin
                    ram.rd_en   = 1'b1;
                    ram.rd_addr = LAST_ROW;
                end
                if (prime_q == 2'd1) ram.rd_en = 1'b1;
                if (prime_q == 2'd3) state_d = RD;
            end
            RD: begin
                if (y_q != LAST_ROW) begin
                    ram.rd_en   = 1'b1;
                    ram.rd_addr = y_q + 1'b1;
                end else if (WRAP != 0) begin
                    ram.rd_en = 1'b1;
                end
                state_d = LATCH;
            end
            LATCH: state_d = CELL;
            CELL: begin
                seed_req = seed_q;
                if (x_q == LAST_COL) state_d = WR;
            end
            WR: begin
                ram.wr_en = 1'b1;
                state_d   = (y_q == LAST_ROW) ? DONE : RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign ram.wr_addr = y_q;
    assign ram.wr_data = row_q;

    assign xm       = (x_q == '0)      ? LAST_COL : x_q - 1'b1;
    assign xp       = (x_q == LAST_COL) ? '0      : x_q + 1'b1;
    assign left_ok  = (WRAP != 0) || (x_q != '0);
    assign right_ok = (WRAP != 0) || (x_q != LAST_COL);
    assign top_w    = {top_q[xp] & right_ok, top_q[x_q], top_q[xm] & left_ok};
    assign mid_w    = {mid_q[xp] & right_ok, mid_q[x_q], mid_q[xm] & left_ok};
    assign bot_w    = {bot_q[xp] & right_ok, bot_q[x_q], bot_q[xm] & left_ok};

    lifegame_cell_rule u_rule (
        .top          (top_w),
        .mid          (mid_w),
        .bot          (bot_w),
        .rule_birth   (birth_q),
        .rule_survive (survive_q),
        .alive        (rule_cell)
    );

    assign new_cell = seed_q ? seed_bit : rule_cell;

    // Cells enter at the MSB, so after COLS shifts cell x sits at bit x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_q   <= '0;
            y_q       <= '0;
            x_q       <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            row_q     <= '0;
            seed_q    <= 1'b0;
            birth_q   <= '0;
            survive_q <= '0;
            pop_acc_q <= '0;
            pop_count <= '0;
            gen_count <= '0;
            buf_sel   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    seed_q    <= seed_mode;
                    birth_q   <= rule_birth;
                    survive_q <= rule_survive;
                    prime_q   <= '0;
                    y_q       <= '0;
                    pop_acc_q <= '0;
                end
                PRIME: begin
                    prime_q <= prime_q + 1'b1;
                    if (prime_q == 2'd1) top_q <= (WRAP != 0) ? ram.rd_data : '0;
                    if (prime_q == 2'd2) mid_q <= ram.rd_data;
                end
                RD:    x_q <= '0;
                LATCH: bot_q <= (y_q == LAST_ROW && WRAP == 0) ? '0 : ram.rd_data;
                CELL: begin
                    row_q     <= {new_cell, row_q[COLS-1:1]};
                    x_q       <= (x_q == LAST_COL) ? '0 : x_q + 1'b1;
                    pop_acc_q <= pop_acc_q + PW'(new_cell);
                end
                WR: begin
                    top_q <= mid_q;
                    mid_q <= bot_q;
                    y_q   <= (y_q == LAST_ROW) ? '0 : y_q + 1'b1;
                end
                DONE: begin
                    pop_count <= pop_acc_q;
                    gen_count <= seed_q ? '0 : gen_count + 1'b1;
                    buf_sel   <= ~buf_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifegame_gen_engine.sv
// Directed bench: a 5x5 bounded engine and an 8x8 toroidal engine, each on its own ping-pong RAM model.
module tb_lifegame_gen_engine;
    import lifegame_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, seed_mode, seed_bit;
    logic [8:0] rule_birth, rule_survive;
    logic       start_a, seed_req_a, buf_sel_a, busy_a, done_a;
    logic [15:0] gen_a;
    logic [4:0]  pop_a;
    logic       start_b, seed_req_b, buf_sel_b, busy_b, done_b;
    logic [15:0] gen_b;
    logic [6:0]  pop_b;

    int n_checks, n_fail;
    logic sel_a, sel_b;
    int gen_a_exp, gen_b_exp;

    lifegame_gen_engine_if #(.COLS(5), .ROWS(5)) ifa ();
    lifegame_gen_engine_if #(.COLS(8), .ROWS(8)) ifb ();

    lifegame_gen_engine #(.COLS(5), .ROWS(5), .WRAP(0), .GEN_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seed_mode(seed_mode), .seed_bit(seed_bit),
        .seed_req(seed_req_a), .rule_birth(rule_birth), .rule_survive(rule_survive), .ram(ifa),
        .buf_sel(buf_sel_a), .busy(busy_a), .done(done_a), .gen_count(gen_a), .pop_count(pop_a)
    );

    lifegame_gen_engine #(.COLS(8), .ROWS(8), .WRAP(1), .GEN_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed_mode(seed_mode), .seed_bit(seed_bit),
        .seed_req(seed_req_b), .rule_birth(rule_birth), .rule_survive(rule_survive), .ram(ifb),
        .buf_sel(buf_sel_b), .busy(busy_b), .done(done_b), .gen_count(gen_b), .pop_count(pop_b)
    );

    // RAM models: read from the DUT's source buffer, write to the other; tasks preload via ld_*.
    logic [4:0] mem_a [2][5];
    logic [7:0] mem_b [2][8];
    logic       ld_a_en, ld_b_en;
    int         ld_a_row, ld_b_row;
    logic [4:0] ld_a_data;
    logic [7:0] ld_b_data;
    int         seed_cnt;

    always @(posedge clk) begin
        if (ifa.rd_en) ifa.rd_data <= mem_a[buf_sel_a][ifa.rd_addr];
        if (ifa.wr_en) mem_a[~buf_sel_a][ifa.wr_addr] <= ifa.wr_data;
        if (ld_a_en)   mem_a[sel_a][ld_a_row] <= ld_a_data;
        if (ifb.rd_en) ifb.rd_data <= mem_b[buf_sel_b][ifb.rd_addr];
        if (ifb.wr_en) mem_b[~buf_sel_b][ifb.wr_addr] <= ifb.wr_data;
        if (ld_b_en)   mem_b[sel_b][ld_b_row] <= ld_b_data;
        if (start_a)         seed_cnt <= 0;
        else if (seed_req_a) seed_cnt <= seed_cnt + 1;
    end

    assign seed_bit = ~seed_cnt[0];

    task automatic load_a(input logic [4:0] f [5]);
        for (int r = 0; r < 5; r++) begin
            ld_a_en = 1'b1; ld_a_row = r; ld_a_data = f[r];
            @(posedge clk); #1;
        end
        ld_a_en = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] f [8]);
        for (int r = 0; r < 8; r++) begin
            ld_b_en = 1'b1; ld_b_row = r; ld_b_data = f[r];
            @(posedge clk); #1;
        end
        ld_b_en = 1'b0;
    endtask

    task automatic run_a(input int restart_at, output int cycles, output int dones);
        bit seen = 1'b0;
        cycles = 0; dones = 0;
        start_a = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            cycles++;
            start_a = (cycles == restart_at);
            if (done_a) begin dones++; seen = 1'b1; break; end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (done_a) dones++;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL run_a timeout: done not seen within %0d cycles", cycles); end
    endtask

    task automatic run_b(output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        start_b = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            cycles++;
            start_b = 1'b0;
            if (done_b) begin seen = 1'b1; break; end
        end
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL run_b timeout: done not seen within %0d cycles", cycles); end
    endtask

    task automatic test_reset;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset busy_a got %b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset done_a got %b want 0", done_a); end
        n_checks++; if (gen_a !== 16'd0) begin n_fail++; $display("FAIL reset gen_a got %0d want 0", gen_a); end
        n_checks++; if (pop_a !== 5'd0) begin n_fail++; $display("FAIL reset pop_a got %0d want 0", pop_a); end
        n_checks++; if ({ifa.rd_en, ifa.wr_en, seed_req_a, buf_sel_a} !== 4'b0) begin
            n_fail++; $display("FAIL reset strobes_a got %b want 0000", {ifa.rd_en, ifa.wr_en, seed_req_a, buf_sel_a});
        end
        n_checks++; if (ifa.wr_data !== 5'd0) begin n_fail++; $display("FAIL reset wr_data_a got %b want 0", ifa.wr_data); end
        n_checks++; if ({busy_b, done_b, seed_req_b, buf_sel_b, ifb.rd_en, ifb.wr_en} !== 6'b0) begin
            n_fail++; $display("FAIL reset strobes_b got %b want 000000", {busy_b, done_b, seed_req_b, buf_sel_b, ifb.rd_en, ifb.wr_en});
        end
        n_checks++; if ({gen_b, pop_b} !== 23'd0) begin n_fail++; $display("FAIL reset counters_b got %0d/%0d want 0/0", gen_b, pop_b); end
    endtask

    task automatic test_blinker;
        logic [4:0] f [5];
        logic [4:0] e [5];
        int cyc, dn;
        f = '{5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000};
        e = '{5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
        load_a(f);
        run_a(0, cyc, dn);
        sel_a = ~sel_a; gen_a_exp++;
        n_checks++; if (cyc != 45) begin n_fail++; $display("FAIL blinker latency got %0d want 45", cyc); end
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL blinker done pulses got %0d want 1", dn); end
        for (int r = 0; r < 5; r++) begin
            n_checks++;
            if (mem_a[sel_a][r] !== e[r]) begin n_fail++; $display("FAIL blinker row%0d got %b want %b", r, mem_a[sel_a][r], e[r]); end
        end
        n_checks++; if (pop_a !== 5'd3) begin n_fail++; $display("FAIL blinker pop got %0d want 3", pop_a); end
        n_checks++; if (gen_a !== 16'(gen_a_exp)) begin n_fail++; $display("FAIL blinker gen got %0d want %0d", gen_a, gen_a_exp); end
        n_checks++; if (buf_sel_a !== sel_a) begin n_fail++; $display("FAIL blinker buf_sel got %b want %b", buf_sel_a, sel_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL blinker busy after done got %b want 0", busy_a); end
    endtask

    task automatic test_corner;
        logic [4:0] fa [5];
        logic [7:0] fb [8];
        int cyc, dn;
        fa = '{5'b10001, 5'b00000, 5'b00000, 5'b00000, 5'b10001};
        load_a(fa);
        run_a(0, cyc, dn);
        sel_a = ~sel_a; gen_a_exp++;
        for (int r = 0; r < 5; r++) begin
            n_checks++;
            if (mem_a[sel_a][r] !== 5'd0) begin n_fail++; $display("FAIL corner_bounded row%0d got %b want 00000", r, mem_a[sel_a][r]); end
        end
        n_checks++; if (pop_a !== 5'd0) begin n_fail++; $display("FAIL corner_bounded pop got %0d want 0", pop_a); end
        fb = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
        load_b(fb);
        run_b(cyc);
        sel_b = ~sel_b; gen_b_exp++;
        n_checks++; if (cyc != 93) begin n_fail++; $display("FAIL corner_torus latency got %0d want 93", cyc); end
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (mem_b[sel_b][r] !== fb[r]) begin n_fail++; $display("FAIL corner_torus row%0d got %b want %b", r, mem_b[sel_b][r], fb[r]); end
        end
        n_checks++; if (pop_b !== 7'd4) begin n_fail++; $display("FAIL corner_torus pop got %0d want 4", pop_b); end
        n_checks++; if (gen_b !== 16'(gen_b_exp)) begin n_fail++; $display("FAIL corner_torus gen got %0d want %0d", gen_b, gen_b_exp); end
    endtask

    task automatic test_glider;
        logic [7:0] g0 [8];
        logic [7:0] g4 [8];
        int cyc;
        g0 = '{8'b00000010, 8'b00000100, 8'b00000111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        g4 = '{8'h00, 8'b00000100, 8'b00001000, 8'b00001110, 8'h00, 8'h00, 8'h00, 8'h00};
        load_b(g0);
        for (int g = 1; g <= 32; g++) begin
            run_b(cyc);
            sel_b = ~sel_b; gen_b_exp++;
            n_checks++; if (pop_b !== 7'd5) begin n_fail++; $display("FAIL glider gen%0d pop got %0d want 5", g, pop_b); end
            if (g == 4) begin
                for (int r = 0; r < 8; r++) begin
                    n_checks++;
                    if (mem_b[sel_b][r] !== g4[r]) begin n_fail++; $display("FAIL glider gen4 row%0d got %b want %b", r, mem_b[sel_b][r], g4[r]); end
                end
            end
            if (g == 32) begin
                for (int r = 0; r < 8; r++) begin
                    n_checks++;
                    if (mem_b[sel_b][r] !== g0[r]) begin n_fail++; $display("FAIL glider gen32 row%0d got %b want %b", r, mem_b[sel_b][r], g0[r]); end
                end
            end
        end
        n_checks++; if (gen_b !== 16'(gen_b_exp)) begin n_fail++; $display("FAIL glider gen got %0d want %0d", gen_b, gen_b_exp); end
    endtask

    task automatic test_seed;
        logic [4:0] e [5];
        int cyc, dn;
        e = '{5'b10101, 5'b01010, 5'b10101, 5'b01010, 5'b10101};
        seed_mode = 1'b1;
        run_a(0, cyc, dn);
        seed_mode = 1'b0;
        sel_a = ~sel_a; gen_a_exp = 0;
        n_checks++; if (seed_cnt != 25) begin n_fail++; $display("FAIL seed seed_req pulses got %0d want 25", seed_cnt); end
        for (int r = 0; r < 5; r++) begin
            n_checks++;
            if (mem_a[sel_a][r] !== e[r]) begin n_fail++; $display("FAIL seed row%0d got %b want %b", r, mem_a[sel_a][r], e[r]); end
        end
        n_checks++; if (pop_a !== 5'd13) begin n_fail++; $display("FAIL seed pop got %0d want 13", pop_a); end
        n_checks++; if (gen_a !== 16'd0) begin n_fail++; $display("FAIL seed gen got %0d want 0", gen_a); end
        n_checks++; if (buf_sel_a !== sel_a) begin n_fail++; $display("FAIL seed buf_sel got %b want %b", buf_sel_a, sel_a); end
    endtask

    task automatic test_rule;
        logic [4:0] f [5];
        int cyc, dn;
        f = '{5'b00000, 5'b01110, 5'b00000, 5'b01110, 5'b00000};
        rule_birth = 9'b001001000;
        load_a(f);
        run_a(0, cyc, dn);
        sel_a = ~sel_a; gen_a_exp++;
        rule_birth = RULE_B3;
        n_checks++; if (mem_a[sel_a][2][2] !== 1'b1) begin n_fail++; $display("FAIL rule_b36 centre got %b want 1", mem_a[sel_a][2][2]); end
        load_a(f);
        run_a(0, cyc, dn);
        sel_a = ~sel_a; gen_a_exp++;
        n_checks++; if (mem_a[sel_a][2][2] !== 1'b0) begin n_fail++; $display("FAIL rule_b3 centre got %b want 0", mem_a[sel_a][2][2]); end
        n_checks++; if (gen_a !== 16'(gen_a_exp)) begin n_fail++; $display("FAIL rule gen got %0d want %0d", gen_a, gen_a_exp); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] f [5];
        int cyc, dn;
        f = '{5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000};
        load_a(f);
        run_a(10, cyc, dn);
        sel_a = ~sel_a; gen_a_exp++;
        n_checks++; if (dn != 1) begin n_fail++; $display("FAIL busy_start done pulses got %0d want 1", dn); end
        n_checks++; if (cyc != 45) begin n_fail++; $display("FAIL busy_start latency got %0d want 45", cyc); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_start busy got %b want 0", busy_a); end
        n_checks++; if (mem_a[sel_a][2] !== 5'b00100) begin n_fail++; $display("FAIL busy_start row2 got %b want 00100", mem_a[sel_a][2]); end
        n_checks++; if (gen_a !== 16'(gen_a_exp)) begin n_fail++; $display("FAIL busy_start gen got %0d want %0d", gen_a, gen_a_exp); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_mid busy before reset got %b want 1", busy_a); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy got %b want 0", busy_a); end
        n_checks++; if (ifa.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_mid wr_en got %b want 0", ifa.wr_en); end
        n_checks++; if (gen_a !== 16'd0) begin n_fail++; $display("FAIL reset_mid gen got %0d want 0", gen_a); end
        n_checks++; if (pop_a !== 5'd0) begin n_fail++; $display("FAIL reset_mid pop got %0d want 0", pop_a); end
        n_checks++; if (buf_sel_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid buf_sel got %b want 0", buf_sel_a); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done_a || busy_a || ifa.wr_en) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL reset_mid activity after reset got %0d cycles want 0", dones); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        start_a = 1'b0; start_b = 1'b0; seed_mode = 1'b0;
        rule_birth = RULE_B3; rule_survive = RULE_S23;
        ld_a_en = 1'b0; ld_b_en = 1'b0; ld_a_row = 0; ld_b_row = 0; ld_a_data = '0; ld_b_data = '0;
        sel_a = 1'b0; sel_b = 1'b0; gen_a_exp = 0; gen_b_exp = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset;
        test_blinker;
        test_corner;
        test_glider;
        test_seed;
        test_rule;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
